// File: rtl/reflet_peripheral_fabric_if.sv
// CPU-side byte bus of the Reflet peripheral fabric.
// The CPU drives the request (master); the fabric answers with data and a
// one-cycle ready pulse (slave).
interface reflet_peripheral_fabric_if #(
  parameter int base_addr_size = 16
) ();
  logic                      enable;
  logic [base_addr_size-1:0] addr;
  logic [7:0]                data_in;
  logic                      write_en;
  logic [7:0]                data_out;
  logic                      ready;

  modport master (
    output enable,
    output addr,
    output data_in,
    output write_en,
    input  data_out,
    input  ready
  );

  modport slave (
    input  enable,
    input  addr,
    input  data_in,
    input  write_en,
    output data_out,
    output ready
  );
endinterface

// File: rtl/reflet_peripheral_fabric.sv
// Reflet peripheral fabric: decodes a CPU address window into n_slots
// equal slots, runs a registered select/ready handshake with the selected
// peripheral, records bus faults and aggregates masked slot interrupts.
// Slot 0 is the fabric's own control block (STATUS, ERR_SLOT, IRQ_MASK,
// IRQ_PEND).
// Optional feature macro: REFLET_FABRIC_TIMEOUT_EN -- when defined, a
// transaction that waits timeout_cycles cycles without slot_ready is
// aborted and flagged in STATUS bit1.
module reflet_peripheral_fabric #(
  parameter int                        base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr      = 16'hFF00,
  parameter int                        n_slots        = 8,
  parameter int                        slot_size_log2 = 3,
  parameter logic [7:0]                slot_present   = 8'hFF,
  parameter int                        timeout_cycles = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  reflet_peripheral_fabric_if.slave    cpu,
  output logic [n_slots-1:0]           slot_sel,
  output logic [slot_size_log2-1:0]    slot_addr,
  output logic [7:0]                   slot_wdata,
  output logic                         slot_we,
  input  logic [8*n_slots-1:0]         slot_rdata,
  input  logic [n_slots-1:0]           slot_ready,
  input  logic [n_slots-1:0]           slot_irq,
  output logic                         irq,
  output logic [2:0]                   irq_id
);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_wait = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [base_addr_size-1:0] window_size =
    base_addr_size'(n_slots << slot_size_log2);

  logic [1:0]                state_reg;
  logic [n_slots-1:0]        slot_sel_reg;
  logic [slot_size_log2-1:0] slot_addr_reg;
  logic [7:0]                slot_wdata_reg;
  logic                      slot_we_reg;
  logic [2:0]                cur_slot_reg;
  logic [7:0]                rdata_reg;
  logic [1:0]                status_reg;
  logic [1:0]                status_next;
  logic [1:0]                status_set;
  logic [1:0]                status_clr;
  logic [2:0]                err_slot_reg;
  logic [n_slots-1:0]        irq_mask_reg;
  logic                      irq_reg;
  logic [2:0]                irq_id_reg;

  logic [base_addr_size-1:0] offset;
  logic                      in_window;
  logic [2:0]                req_slot;
  logic [slot_size_log2-1:0] req_reg;
  logic                      req_idle;
  logic                      req_internal;
  logic                      req_absent;
  logic [7:0]                int_rdata;
  logic [n_slots-1:0]        pend;
  logic [2:0]                pend_id;
  logic                      cur_ready;
  logic                      timeout_hit;

  // Bit 0 of slot_irq belongs to the internal slot and carries no meaning.
  logic unused_slot_irq0;
  assign unused_slot_irq0 = slot_irq[0];

  // Window decode; the window base is aligned so the offset splits cleanly.
  assign offset       = cpu.addr - base_addr;
  assign in_window    = cpu.enable && (cpu.addr >= base_addr) && (offset < window_size);
  assign req_slot     = offset[slot_size_log2 +: 3];
  assign req_reg      = offset[slot_size_log2-1:0];
  assign req_idle     = (state_reg == st_idle) && in_window;
  assign req_internal = req_idle && (req_slot == 3'd0);
  assign req_absent   = req_idle && (req_slot != 3'd0) && !slot_present[req_slot];
  assign cur_ready    = slot_ready[cur_slot_reg];

`ifdef REFLET_FABRIC_TIMEOUT_EN
  logic [7:0] count_reg;

  // Count WAIT cycles; any other state rearms the counter at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= 8'd0;
    end else if (state_reg == st_wait) begin
      count_reg <= count_reg + 8'd1;
    end else begin
      count_reg <= 8'd0;
    end
  end

  assign timeout_hit = (state_reg == st_wait) && (count_reg == 8'(timeout_cycles - 1));
`else
  localparam int unused_timeout_cycles = timeout_cycles;
  assign timeout_hit = 1'b0;
`endif

  // Control-block read mux; registers 4 and up read as zero.
  always_comb begin
    int_rdata = 8'h00;
    if (32'(req_reg) < 4) begin
      case (req_reg[1:0])
        2'd0:    int_rdata = {6'b0, status_reg};
        2'd1:    int_rdata = {5'b0, err_slot_reg};
        2'd2:    int_rdata = 8'(irq_mask_reg);
        default: int_rdata = 8'(pend);
      endcase
    end
  end

  // Sticky fault flags: write-1-clear, with a simultaneous fault winning.
  always_comb begin
    status_set    = 2'b00;
    status_clr    = 2'b00;
    status_set[0] = req_absent;
    status_set[1] = (state_reg == st_wait) && !cur_ready && timeout_hit;
    if (req_internal && cpu.write_en && (32'(req_reg) == 0)) begin
      status_clr = cpu.data_in[1:0];
    end
    status_next = (status_reg & ~status_clr) | status_set;
  end

  // Register the sticky fault flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      status_reg <= 2'b00;
    end else begin
      status_reg <= status_next;
    end
  end

  // Transaction FSM with the registered peripheral-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= st_idle;
      slot_sel_reg   <= '0;
      slot_addr_reg  <= '0;
      slot_wdata_reg <= 8'h00;
      slot_we_reg    <= 1'b0;
      cur_slot_reg   <= 3'd0;
      rdata_reg      <= 8'h00;
      err_slot_reg   <= 3'd0;
      irq_mask_reg   <= '0;
    end else begin
      case (state_reg)
        st_idle: begin
          if (req_internal) begin
            rdata_reg <= cpu.write_en ? 8'h00 : int_rdata;
            if (cpu.write_en && (32'(req_reg) == 2)) begin
              irq_mask_reg <= cpu.data_in[n_slots-1:0];
            end
            state_reg <= st_done;
          end else if (req_absent) begin
            rdata_reg    <= 8'h00;
            err_slot_reg <= req_slot;
            state_reg    <= st_done;
          end else if (req_idle) begin
            slot_sel_reg   <= {{(n_slots-1){1'b0}}, 1'b1} << req_slot;
            slot_addr_reg  <= req_reg;
            slot_wdata_reg <= cpu.data_in;
            slot_we_reg    <= cpu.write_en;
            cur_slot_reg   <= req_slot;
            state_reg      <= st_wait;
          end
        end
        st_wait: begin
          if (cur_ready) begin
            rdata_reg    <= slot_we_reg ? 8'h00 : slot_rdata[8*cur_slot_reg +: 8];
            slot_sel_reg <= '0;
            slot_we_reg  <= 1'b0;
            state_reg    <= st_done;
          end else if (timeout_hit) begin
            rdata_reg    <= 8'h00;
            slot_sel_reg <= '0;
            slot_we_reg  <= 1'b0;
            err_slot_reg <= cur_slot_reg;
            state_reg    <= st_done;
          end
        end
        st_done: begin
          state_reg <= st_idle;
        end
        default: begin
          state_reg <= st_idle;
        end
      endcase
    end
  end

  // Pending interrupts: slot 0 reflects the fault flags, others the slot lines.
  assign pend[0] = (|status_reg) & irq_mask_reg[0];
  generate
    for (genvar gi = 1; gi < n_slots; gi++) begin : g_pend
      assign pend[gi] = slot_irq[gi] & irq_mask_reg[gi];
    end
  endgenerate

  // Lowest pending slot wins; zero when nothing is pending.
  always_comb begin
    pend_id = 3'd0;
    for (int i = n_slots - 1; i >= 0; i--) begin
      if (pend[i]) begin
        pend_id = 3'(i);
      end
    end
  end

  // Register the interrupt summary one cycle behind its sources.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_reg    <= 1'b0;
      irq_id_reg <= 3'd0;
    end else begin
      irq_reg    <= |pend;
      irq_id_reg <= pend_id;
    end
  end

  assign cpu.ready    = (state_reg == st_done);
  assign cpu.data_out = (state_reg == st_done) ? rdata_reg : 8'h00;
  assign slot_sel     = slot_sel_reg;
  assign slot_addr    = slot_addr_reg;
  assign slot_wdata   = slot_wdata_reg;
  assign slot_we      = slot_we_reg;
  assign irq          = irq_reg;
  assign irq_id       = irq_id_reg;

endmodule
